// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the execute-stage controller and seq_alu.
// The controller drives the master side: start, function code and operands.
// The ALU drives the slave side: result, flags, busy and done.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       ALUfunct;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;
    logic             flagZ;
    logic             flagS;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUfunct, A, B,
        input  out, flagZ, flagS, busy, done
    );

    modport slave (
        input  start, ALUfunct, A, B,
        output out, flagZ, flagS, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with a start/done handshake and registered result and flags.
// Single-cycle logic ops complete in one cycle. Shifts iterate one bit per clock.
// Define SEQ_ALU_MUL_EN to compile in the shift-add multiplier for code 011000.
// Without that macro, 011000 behaves as an undefined code and passes A through.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    // The counter must hold WIDTH for the multiplier, so it has one bit more than a shift amount.
    localparam int CW = SHW + 1;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOT = 6'b100111;
    localparam logic [5:0] F_SLA = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [5:0] F_MUL = 6'b011000;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_shop;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_flag_z;
    logic             r_flag_s;
    logic             r_done;
    logic             r_busy;
`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic [WIDTH-1:0] w_prod_step;
`endif

    logic [SHW-1:0]   w_n;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_acc_step;

    assign w_n        = bus.B[SHW-1:0];
    assign w_is_shift = (bus.ALUfunct == F_SLA) || (bus.ALUfunct == F_SRL) ||
                        (bus.ALUfunct == F_SRA);

    // One-cycle result; shifts with n=0 and every undefined code fall through to pass A.
    always_comb begin
        w_single = bus.A;
        case (bus.ALUfunct)
            F_ADD:   w_single = bus.A + bus.B;
            F_SUB:   w_single = bus.A - bus.B;
            F_AND:   w_single = bus.A & bus.B;
            F_OR:    w_single = bus.A | bus.B;
            F_XOR:   w_single = bus.A ^ bus.B;
            F_NOT:   w_single = ~bus.A;
            default: w_single = bus.A;
        endcase
    end

    // One-bit step of the shift accumulator; the low two function bits select the shift kind.
    always_comb begin
        w_acc_step = r_acc;
        case (r_shop)
            2'b00:   w_acc_step = {r_acc[WIDTH-2:0], 1'b0};
            2'b10:   w_acc_step = {1'b0, r_acc[WIDTH-1:1]};
            2'b11:   w_acc_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            default: w_acc_step = r_acc;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // Conditional add of the shifted multiplicand for the current multiplier bit.
    assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
`endif

    // Control FSM and datapath; out and the flags change only when an operation completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_shop   <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_flag_z <= 1'b0;
            r_flag_s <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_is_shift && (w_n != '0)) begin
                            r_acc   <= bus.A;
                            r_cnt   <= {1'b0, w_n};
                            r_shop  <= bus.ALUfunct[1:0];
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                        end
`ifdef SEQ_ALU_MUL_EN
                        else if (bus.ALUfunct == F_MUL) begin
                            r_mcand  <= bus.A;
                            r_mplier <= bus.B;
                            r_prod   <= '0;
                            r_cnt    <= CW'(WIDTH);
                            r_state  <= S_MUL;
                            r_busy   <= 1'b1;
                        end
`endif
                        else begin
                            r_out    <= w_single;
                            r_flag_z <= (w_single == '0);
                            r_flag_s <= w_single[WIDTH-1];
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out    <= w_acc_step;
                        r_flag_z <= (w_acc_step == '0);
                        r_flag_s <= w_acc_step[WIDTH-1];
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_MUL: begin
                    r_prod   <= w_prod_step;
                    r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out    <= w_prod_step;
                        r_flag_z <= (w_prod_step == '0);
                        r_flag_s <= w_prod_step[WIDTH-1];
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out   = r_out;
    assign bus.flagZ = r_flag_z;
    assign bus.flagS = r_flag_s;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule
